div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit integer divider for MIPS DIV/DIVU in the execute stage. It drives the hazard unit's `stall_divE` input, which holds F/D/E while a divide runs. On completion it presents the {HI, LO} result to the HI/LO write path. Radix-2 restoring algorithm, one quotient bit per cycle. Supports cancellation by an exception flush.

## Interface

- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  core clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  a divide instruction is valid in the E stage. Held high until `ready`.
- `signed_div`  in  1  1 = DIV, 0 = DIVU. Sampled with `start`.
- `a`  in  WIDTH  dividend (rs). Sampled only on the accepting cycle.
- `b`  in  WIDTH  divisor (rt). Sampled only on the accepting cycle.
- `annul`  in  1  exception flush (`flush_exceptM`). Abandons the operation in progress.
- `stall_div`  out  1  feeds `stall_divE` = `start & ~ready`. Combinational.
- `ready`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  2*WIDTH  {HI = remainder, LO = quotient}. Registered.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On `start & ~annul`, latch |a|, |b| (absolute value when `signed_div`), sign(a), sign(a)^sign(b), and clear the partial remainder.
  - Iteration counter set to `WIDTH`. Next state BUSY.
- BUSY, each cycle:
  - Form rem' = {rem, next dividend MSB}.
  - If rem' >= |b|: rem = rem' - |b| and the quotient bit is 1. Otherwise rem = rem' and the quotient bit is 0.
  - Decrement the counter. At 0, go to DONE.
  - Remainder path is WIDTH+1 bits.
- Entering DONE registers the sign fix-up:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE: `ready`=1 for exactly one cycle. Next state IDLE.
- IDLE can accept a new `start` on the cycle after DONE, which supports back-to-back divides.
- Unsigned mode: no fix-up.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- Divide by zero, natural restoring result: LO=all ones, HI=|a| with sign fix-up applied. Architecturally undefined; no exception is raised.
- `annul` in any state: next state IDLE, no `ready`, `result` unchanged. `annul` has priority over a simultaneous `start`.
- `start` dropping while BUSY without `annul` is illegal (an E-stage flush implies `annul`). The bench asserts against it.

## Timing

- Reset values: state IDLE, `ready`=0, `result`=0, counter 0. `stall_div`=0 while `start`=0.
- Accept cycle = cycle 0, with `stall_div`=1 that cycle.
- Iterations occupy cycles 1..WIDTH.
- DONE is cycle WIDTH+1 (33): `ready`=1, `stall_div`=0, and the E stage advances.
- The instruction occupies E for 34 cycles.
- `result` holds its value until the next DONE.
- `annul` asserted in cycle k: the block is IDLE in cycle k+1.
- Reset mid-operation: immediate IDLE with all outputs at reset values.

## Configuration

- `DIV_ZERO_FAST_EN`:
  - Defined: a zero divisor on accept goes straight to DONE in cycle 1 with LO=0xFFFFFFFF and HI=a, identical to the natural unsigned result, with no sign fix-up. Stall is 1 cycle.
  - Undefined: a zero divisor runs the full 32 iterations with the natural result and sign fix-up.

## Structure

- Shared package `cpu_pkg`:
  - state enum `div_state_t` (IDLE/BUSY/DONE)
  - `DIV_ITERS` = 32
  - HI/LO slice constants for `result`
- Single module. The iteration step is small enough to stay inline, so no sub-module.

## Test plan

- DIVU 100 / 7 -> `ready` at cycle 33; LO=14, HI=2; `stall_div` high cycles 0–32.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 7 / -2 -> LO=-3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0xFFFFFFFF / 1 -> LO=0xFFFFFFFF, HI=0.
- DIVU 5 / 0:
  - Without the macro -> cycle 33, LO=0xFFFFFFFF, HI=5.
  - With `DIV_ZERO_FAST_EN` -> `ready` at cycle 1 with the same values.
- `annul` at cycle 10 -> IDLE at cycle 11, no `ready`, `result` unchanged. A new `start` with 9/3 then gives LO=3, HI=0.
- `resetn` low at cycle 20 -> `ready`=0, `result`=0, IDLE. Back-to-back divides give `ready` pulses 34 cycles apart.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions used by the execute-stage divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;

    // Field positions of {HI, LO} inside the divider result
    localparam int RESULT_LO_LSB = 0;
    localparam int RESULT_LO_MSB = DIV_ITERS - 1;
    localparam int RESULT_HI_LSB = DIV_ITERS;
    localparam int RESULT_HI_MSB = 2 * DIV_ITERS - 1;

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Execute-stage handshake between the pipeline and the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 annul;
    logic                 stall_div;
    logic                 ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_div, a, b, annul,
        input  stall_div, ready, result
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output stall_div, ready, result
    );

endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Radix-2 restoring divider for MIPS DIV/DIVU, one quotient
//                bit per cycle. Optional macro DIV_ZERO_FAST_EN short-cuts a
//                zero divisor straight to DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
)(
    input  wire logic   clk,
    input  wire logic   resetn,
    div_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_ITERS = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    div_state_t         r_state;
    div_state_t         w_nextState;

    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_count;
    logic               r_negQuot;
    logic               r_negRem;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_lastIter;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aAbs;
    logic [WIDTH-1:0]   w_bAbs;
    logic [WIDTH:0]     w_remShift;
    logic               w_qBit;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quotNext;
    logic [WIDTH-1:0]   w_quotFinal;
    logic [WIDTH-1:0]   w_remFinal;
`ifdef DIV_ZERO_FAST_EN
    logic               w_zeroDiv;

    assign w_zeroDiv = (bus.b == '0);
`endif

    assign w_accept   = (r_state == IDLE) & bus.start & ~bus.annul;
    assign w_lastIter = (r_state == BUSY) & (r_count == c_ONE);

    assign w_aNeg = bus.signed_div & bus.a[WIDTH-1];
    assign w_bNeg = bus.signed_div & bus.b[WIDTH-1];
    assign w_aAbs = w_aNeg ? -bus.a : bus.a;
    assign w_bAbs = w_bNeg ? -bus.b : bus.b;

    // The shifted remainder is WIDTH+1 bits; its MSB set always means rem' >= |b|
    assign w_remShift = {r_rem, r_shift[WIDTH-1]};
    assign w_qBit     = w_remShift[WIDTH] | (w_remShift[WIDTH-1:0] >= r_divisor);
    assign w_remNext  = w_qBit ? (w_remShift[WIDTH-1:0] - r_divisor)
                               : w_remShift[WIDTH-1:0];
    assign w_quotNext = {r_shift[WIDTH-2:0], w_qBit};

    assign w_quotFinal = r_negQuot ? -w_quotNext : w_quotNext;
    assign w_remFinal  = r_negRem  ? -w_remNext  : w_remNext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.annul) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
`ifdef DIV_ZERO_FAST_EN
                        w_nextState = w_zeroDiv ? DONE : BUSY;
`else
                        w_nextState = BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (w_lastIter) begin
                        w_nextState = DONE;
                    end
                end
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_divisor <= '0;
            r_rem     <= '0;
            r_shift   <= '0;
            r_count   <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_divisor <= w_bAbs;
            r_shift   <= w_aAbs;
            r_rem     <= '0;
            r_count   <= c_ITERS;
            r_negQuot <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
`ifdef DIV_ZERO_FAST_EN
            if (w_zeroDiv) begin
                r_result <= {bus.a, {WIDTH{1'b1}}};
            end
`endif
        end else if (bus.annul) begin
            r_count <= '0;
        end else if (r_state == BUSY) begin
            r_rem   <= w_remNext;
            r_shift <= w_quotNext;
            r_count <= r_count - c_ONE;
            // Sign fix-up is folded into the final iteration's write
            if (w_lastIter) begin
                r_result <= {w_remFinal, w_quotFinal};
            end
        end
    end

    assign bus.ready     = (r_state == DONE) & ~bus.annul;
    assign bus.stall_div = bus.start & ~bus.ready;
    assign bus.result    = r_result;

endmodule
`default_nettype wire
